// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and datapath width shared by the ALU
// sequencer and its divide step.
// Build option: ALU_SEQUENCER_SIGNED_DIV_EN enables signed DIV/REM (ops 21/22).
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd4;
  localparam logic [4:0] OP_AND    = 5'd5;
  localparam logic [4:0] OP_NOT    = 5'd6;
  localparam logic [4:0] OP_XOR    = 5'd7;
  localparam logic [4:0] OP_CMP    = 5'd8;
  localparam logic [4:0] OP_MOV    = 5'd9;
  localparam logic [4:0] OP_SHL    = 5'd12;
  localparam logic [4:0] OP_SHR    = 5'd13;
  localparam logic [4:0] OP_MULL16 = 5'd16;
  localparam logic [4:0] OP_MULLO  = 5'd17;
  localparam logic [4:0] OP_MULHI  = 5'd18;
  localparam logic [4:0] OP_DIVU   = 5'd19;
  localparam logic [4:0] OP_REMU   = 5'd20;
  localparam logic [4:0] OP_DIV    = 5'd21;
  localparam logic [4:0] OP_REM    = 5'd22;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_e;

  // True for opcodes handled by the sequencer's own divider rather than the ALU.
  function automatic logic is_div_op(input logic [4:0] op);
    logic hit;
    hit = (op == OP_DIVU) || (op == OP_REMU);
`ifdef ALU_SEQUENCER_SIGNED_DIV_EN
    hit = hit || (op == OP_DIV) || (op == OP_REM);
`endif
    return hit;
  endfunction

  // True for the remainder flavours (result comes from the remainder register).
  function automatic logic is_rem_op(input logic [4:0] op);
    return (op == OP_REMU) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one MSB-first restoring-division iteration. The shifted
// remainder is one bit wider than the datapath so the compare never wraps.
module div_step #(
  parameter int W = alu_pkg::WIDTH
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] divisor_i,
  input  logic         bit_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0] shifted_s;

  // Shift in the next dividend bit and subtract the divisor when it fits.
  always_comb begin
    shifted_s = {rem_i, bit_i};
    if (shifted_s >= {1'b0, divisor_i}) begin
      rem_o = shifted_s[W-1:0] - divisor_i;
      q_o   = 1'b1;
    end else begin
      rem_o = shifted_s[W-1:0];
      q_o   = 1'b0;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: issue/capture stage around the external combinational ALU,
// adding a multi-cycle restoring divider for DIVU/REMU (and DIV/REM).
// Build option: ALU_SEQUENCER_SIGNED_DIV_EN enables signed ops 21/22; when
// undefined they fall through to the ALU like any other unknown opcode.
module alu_sequencer #(
  parameter int WIDTH      = alu_pkg::WIDTH,
  parameter int DIV_CYCLES = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [7:0]       op_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             is_zero,
  output logic             is_negative,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [7:0]       alu_op,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_zero,
  input  logic             alu_neg
);

  import alu_pkg::*;

  localparam int CNT_W = $clog2(DIV_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [7:0]       op_q, op_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, neg_q, neg_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, dsr_q, dsr_d, quo_q, quo_d, rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [4:0]       op5_s;
  logic             is_div_s, is_rem_s;
  logic [WIDTH-1:0] abs_a_s, abs_b_s;
  logic [WIDTH-1:0] step_rem_s;
  logic             step_q_s;
  logic [WIDTH-1:0] raw_s, fix_val_s;

  assign op5_s    = op_q[4:0];
  assign is_div_s = is_div_op(op5_s);
  assign is_rem_s = is_rem_op(op5_s);

`ifdef ALU_SEQUENCER_SIGNED_DIV_EN
  logic is_signed_s;
  assign is_signed_s = (op5_s == OP_DIV) || (op5_s == OP_REM);

  // Magnitudes fed to the unsigned divider for the signed opcodes.
  always_comb begin
    if (is_signed_s && a_q[WIDTH-1]) begin
      abs_a_s = -a_q;
    end else begin
      abs_a_s = a_q;
    end
    if (is_signed_s && b_q[WIDTH-1]) begin
      abs_b_s = -b_q;
    end else begin
      abs_b_s = b_q;
    end
  end
`else
  assign abs_a_s = a_q;
  assign abs_b_s = b_q;
`endif

  div_step #(.W(WIDTH)) u_div_step (
    .rem_i     (rem_q),
    .divisor_i (dsr_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .rem_o     (step_rem_s),
    .q_o       (step_q_s)
  );

  // Final divide value: zero-divisor convention, then sign correction.
  always_comb begin
    raw_s = is_rem_s ? rem_q : quo_q;
    if (b_q == ZERO_W) begin
      fix_val_s = is_rem_s ? a_q : ONES_W;
    end else begin
`ifdef ALU_SEQUENCER_SIGNED_DIV_EN
      if (is_signed_s && (is_rem_s ? a_q[WIDTH-1] : (a_q[WIDTH-1] ^ b_q[WIDTH-1]))) begin
        fix_val_s = -raw_s;
      end else begin
        fix_val_s = raw_s;
      end
`else
      fix_val_s = raw_s;
`endif
    end
  end

  // Next-state and datapath update for the IDLE/EXEC/DIV/FIX sequencer.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    done_d   = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          op_d    = op_in;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (is_div_s) begin
          dvd_d = abs_a_s;
          dsr_d = abs_b_s;
          quo_d = ZERO_W;
          rem_d = ZERO_W;
          cnt_d = {CNT_W{1'b0}};
          if (b_q == ZERO_W) begin
            state_d = FIX;
          end else begin
            state_d = DIV;
          end
        end else begin
          result_d = alu_c;
          zero_d   = alu_zero;
          neg_d    = alu_neg;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      DIV: begin
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        rem_d = step_rem_s;
        quo_d = {quo_q[WIDTH-2:0], step_q_s};
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
        end else begin
          state_d = DIV;
        end
      end
      FIX: begin
        result_d = fix_val_s;
        zero_d   = (fix_val_s == ZERO_W);
        neg_d    = fix_val_s[WIDTH-1];
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, operand, divider and output registers; reset aborts any operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= ZERO_W;
      b_q      <= ZERO_W;
      op_q     <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= ZERO_W;
      zero_q   <= 1'b1;
      neg_q    <= 1'b0;
      dvd_q    <= ZERO_W;
      dsr_q    <= ZERO_W;
      quo_q    <= ZERO_W;
      rem_q    <= ZERO_W;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign is_zero     = zero_q;
  assign is_negative = neg_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;

endmodule
